// File: rtl/snn_argmax_seq.sv
// Sequential arg-max over the SNN output potentials: snapshot on start, then scan LANES
// elements per enabled beat, reporting winner index, value, margin to runner-up and tie.
module snn_argmax_seq #(
    parameter int unsigned VEC_LEN = 10,
    parameter int unsigned DATA_W  = 48,
    parameter int unsigned LANES   = 2,
    localparam int unsigned IDX_W  = $clog2(VEC_LEN)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clk_enable,
    input  logic                        i_start,
    input  logic [VEC_LEN*DATA_W-1:0]   i_potentials_flat,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [IDX_W-1:0]            o_predicted_class,
    output logic signed [DATA_W-1:0]    o_max_value,
    output logic [DATA_W-1:0]           o_margin,
    output logic                        o_tie
);

    localparam int unsigned NBEATS = (VEC_LEN + LANES - 1) / LANES;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {StIdle, StScan} state_e;

    state_e                     state_q;
    logic [VEC_LEN*DATA_W-1:0]  snap_q;
    logic [BEAT_W-1:0]          beat_q;
    logic signed [DATA_W-1:0]   best_q;
    logic signed [DATA_W-1:0]   second_q;
    logic [IDX_W-1:0]           best_idx_q;

    logic signed [DATA_W-1:0]   best_d;
    logic signed [DATA_W-1:0]   second_d;
    logic [IDX_W-1:0]           best_idx_d;
    logic signed [DATA_W-1:0]   cand;
    logic signed [DATA_W:0]     diff;
    logic                       last_beat;

    assign last_beat = (beat_q == BEAT_W'(NBEATS - 1));

    // Lanes are merged in ascending index order, so strict '>' keeps the lowest index on ties
    // and an equal candidate falls through to the runner-up slot.
    always_comb begin
        int unsigned k;
        k          = 0;
        best_d     = best_q;
        second_d   = second_q;
        best_idx_d = best_idx_q;
        cand       = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            k = 32'(beat_q) * LANES + l;
            if (k < VEC_LEN) begin
                cand = snap_q[k*DATA_W +: DATA_W];
                if (cand > best_d) begin
                    second_d   = best_d;
                    best_d     = cand;
                    best_idx_d = IDX_W'(k);
                end else if (cand >= second_d) begin
                    second_d = cand;
                end
            end
        end
        diff = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            snap_q            <= '0;
            beat_q            <= '0;
            best_q            <= '0;
            second_q          <= '0;
            best_idx_q        <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_predicted_class <= '0;
            o_max_value       <= '0;
            o_margin          <= '0;
            o_tie             <= 1'b0;
        end else if (i_clk_enable) begin
            o_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        snap_q     <= i_potentials_flat;
                        beat_q     <= '0;
                        best_q     <= MOST_NEG;
                        second_q   <= MOST_NEG;
                        best_idx_q <= '0;
                        o_busy     <= 1'b1;
                        state_q    <= StScan;
                    end
                end
                StScan: begin
                    best_q     <= best_d;
                    second_q   <= second_d;
                    best_idx_q <= best_idx_d;
                    if (last_beat) begin
                        o_predicted_class <= best_idx_d;
                        o_max_value       <= best_d;
                        o_margin          <= diff[DATA_W-1:0];
                        o_tie             <= (diff == '0);
                        o_done            <= 1'b1;
                        o_busy            <= 1'b0;
                        state_q           <= StIdle;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_argmax_seq.sv
// Scoreboard bench for snn_argmax_seq: drivers queue expected results and done cycles,
// per-instance monitors pop and compare whenever o_done is seen.
module tb_snn_argmax_seq;

    localparam int VL = 10;
    localparam int DW = 48;

    typedef struct {
        logic [3:0]    cls;
        logic [DW-1:0] max;
        logic [DW-1:0] margin;
        logic          tie;
        int unsigned   dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic start = 1'b0;
    logic start10 = 1'b0;
    logic start1 = 1'b0;
    logic [VL*DW-1:0] pot = '0;

    logic busy3, done3, tie3, busy10, done10, tie10, busy1, done1, tie1;
    logic [3:0] cls3, cls10, cls1;
    logic signed [DW-1:0] max3, max10, max1;
    logic [DW-1:0] mar3, mar10, mar1;

    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t q3[$];
    exp_t q10[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    snn_argmax_seq #(.VEC_LEN(VL), .DATA_W(DW), .LANES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_clk_enable(en), .i_start(start),
        .i_potentials_flat(pot), .o_busy(busy3), .o_done(done3),
        .o_predicted_class(cls3), .o_max_value(max3), .o_margin(mar3), .o_tie(tie3)
    );

    snn_argmax_seq #(.VEC_LEN(VL), .DATA_W(DW), .LANES(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .i_clk_enable(1'b1), .i_start(start10),
        .i_potentials_flat(pot), .o_busy(busy10), .o_done(done10),
        .o_predicted_class(cls10), .o_max_value(max10), .o_margin(mar10), .o_tie(tie10)
    );

    snn_argmax_seq #(.VEC_LEN(VL), .DATA_W(DW), .LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_clk_enable(1'b1), .i_start(start1),
        .i_potentials_flat(pot), .o_busy(busy1), .o_done(done1),
        .o_predicted_class(cls1), .o_max_value(max1), .o_margin(mar1), .o_tie(tie1)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic chk_res(input string tag, input exp_t e, input logic [3:0] c,
                           input logic [DW-1:0] m, input logic [DW-1:0] g, input logic t);
        chk({tag, ".class"}, DW'(c), DW'(e.cls));
        chk({tag, ".max"}, m, e.max);
        chk({tag, ".margin"}, g, e.margin);
        chk({tag, ".tie"}, DW'(t), DW'(e.tie));
        chk({tag, ".done_cycle"}, DW'(cyc), DW'(e.dc));
    endtask

    task automatic unexpected(input string tag);
        checks++;
        failures++;
        $display("FAIL %s.unexpected_done: got done at cycle %0d, required none", tag, cyc);
    endtask

    always @(negedge clk) if (done3) begin
        if (q3.size() == 0) unexpected("dut3");
        else chk_res("dut3", q3.pop_front(), cls3, max3, mar3, tie3);
    end
    always @(negedge clk) if (done10) begin
        if (q10.size() == 0) unexpected("dut10");
        else chk_res("dut10", q10.pop_front(), cls10, max10, mar10, tie10);
    end
    always @(negedge clk) if (done1) begin
        if (q1.size() == 0) unexpected("dut1");
        else chk_res("dut1", q1.pop_front(), cls1, max1, mar1, tie1);
    end

    function automatic exp_t mk(input logic [3:0] c, input logic signed [DW-1:0] m,
                                input logic [DW-1:0] g, input logic t, input int unsigned dc);
        exp_t e;
        e.cls = c; e.max = m; e.margin = g; e.tie = t; e.dc = dc;
        return e;
    endfunction

    // 0: ramp 100*k with element 7 = 5000; 1: all-negative with a tie; 2: extremes
    function automatic logic [VL*DW-1:0] vec(input int sel);
        logic signed [DW-1:0] e [VL];
        int neg [VL] = '{-5, -3, -9, -3, -20, -7, -8, -6, -11, -4};
        logic [VL*DW-1:0] f;
        for (int k = 0; k < VL; k++) begin
            if (sel == 0) e[k] = 100 * k;
            else if (sel == 1) e[k] = neg[k];
            else e[k] = {1'b1, {(DW-1){1'b0}}};
        end
        if (sel == 0) e[7] = 5000;
        if (sel == 2) e[9] = {1'b0, {(DW-1){1'b1}}};
        for (int k = 0; k < VL; k++) f[k*DW +: DW] = e[k];
        return f;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, DW'(busy3), '0);
        chk({tag, ".done"}, DW'(done3), '0);
        chk({tag, ".class"}, DW'(cls3), '0);
        chk({tag, ".max"}, max3, '0);
        chk({tag, ".margin"}, mar3, '0);
        chk({tag, ".tie"}, DW'(tie3), '0);
    endtask

    task automatic wait_drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (q3.size() == 0 && q10.size() == 0 && q1.size() == 0 &&
                !busy3 && !busy10 && !busy1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s.timeout: got pending=%0d, required 0", tag,
                     q3.size() + q10.size() + q1.size());
        end
    endtask

    localparam logic signed [DW-1:0] BIG = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] ALL1 = {DW{1'b1}};

    initial begin
        int unsigned c0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic ramp: done after E4
        pot = vec(0); start = 1'b1;
        q3.push_back(mk(4'd7, 5000, 4100, 1'b0, cyc + 5));
        @(negedge clk);
        start = 1'b0; pot = vec(1);
        chk("ramp.busy", DW'(busy3), 1);
        wait_drain("ramp");

        pot = vec(1); start = 1'b1;
        q3.push_back(mk(4'd1, -3, 0, 1'b1, cyc + 5));
        @(negedge clk);
        start = 1'b0;
        wait_drain("neg");

        pot = vec(2); start = 1'b1;
        q3.push_back(mk(4'd9, BIG, ALL1, 1'b0, cyc + 5));
        @(negedge clk);
        start = 1'b0;
        wait_drain("ext");

        // Gating, snapshot and ignored starts: three disabled edges delay done by three
        c0 = cyc + 1;
        pot = vec(0); start = 1'b1;
        q3.push_back(mk(4'd7, 5000, 4100, 1'b0, c0 + 7));
        @(negedge clk);
        start = 1'b0; pot = vec(1);
        @(negedge clk);
        en = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("gate.busy", DW'(busy3), 1);
        en = 1'b1;
        @(negedge clk);
        start = 1'b0; pot = vec(2);
        wait_drain("gate");

        // Reset in beat 2 aborts the scan
        pot = vec(1); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort.idle", DW'(busy3), 0);

        // Back-to-back: start held through the done cycle
        c0 = cyc + 1;
        pot = vec(1); start = 1'b1;
        q3.push_back(mk(4'd1, -3, 0, 1'b1, c0 + 4));
        q3.push_back(mk(4'd9, BIG, ALL1, 1'b0, c0 + 9));
        @(negedge clk);
        pot = vec(2);
        repeat (5) @(negedge clk);
        start = 1'b0; pot = vec(0);
        chk("b2b.busy", DW'(busy3), 1);
        chk("b2b.done_low", DW'(done3), 0);
        wait_drain("b2b");

        // Single-beat and one-lane instances on the ramp vector
        c0 = cyc + 1;
        pot = vec(0); start10 = 1'b1; start1 = 1'b1;
        q10.push_back(mk(4'd7, 5000, 4100, 1'b0, c0 + 1));
        q1.push_back(mk(4'd7, 5000, 4100, 1'b0, c0 + 10));
        @(negedge clk);
        start10 = 1'b0; start1 = 1'b0; pot = vec(1);
        wait_drain("lanes");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
